// File: rtl/updown_count_controller_if.sv
// Command channel of updown_count_controller: valid/ready target
// handshake plus abort, busy and done status. master=caller, slave=ctrl.
interface updown_count_controller_if #(
  parameter int WIDTH = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_wrap;
  logic             abort;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_wrap,
    output abort,
    input  cmd_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_wrap,
    input  abort,
    output cmd_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/updown_count_controller.sv
// Steps a WIDTH-bit up/down counter to a commanded target, one count
// per DWELL cycles. Ports: clk, rst (sync, high), cmd (slave side of
// updown_count_controller_if), count, dir (1=down), en (step strobe).
// UDC_STEP_LOG_EN adds step_cnt: steps taken by the last command.
module updown_count_controller #(
  parameter int WIDTH = 3,
  parameter int DWELL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_count_controller_if.slave cmd,
  output logic [WIDTH-1:0]       count,
  output logic                   dir,
`ifdef UDC_STEP_LOG_EN
  output logic [WIDTH:0]         step_cnt,
`endif
  output logic                   en
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  localparam logic [WIDTH-1:0] HALF =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] target_d;
  logic             dir_q;
  logic             dir_d;
  logic [DW-1:0]    dwell_q;
  logic [DW-1:0]    dwell_d;

`ifdef UDC_STEP_LOG_EN
  logic [WIDTH:0]   step_q;
  logic [WIDTH:0]   step_d;
`endif

  logic             accept;
  logic             step_en;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] up_dist;
  logic             lin_down;
  logic             mod_down;

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign accept  = cmd.cmd_valid && cmd.cmd_ready;
  assign step_en = (state_q == RUN) && (dwell_q == '0);

  assign cmd.busy = (state_q != IDLE);
  assign cmd.done = (state_q == DONE);

  assign count = count_q;
  assign dir   = dir_q;
  assign en    = step_en;

`ifdef UDC_STEP_LOG_EN
  assign step_cnt = step_q;
`endif

  // Up distance is taken modulo 2^WIDTH; a tie at half range goes up.
  assign up_dist  = cmd.cmd_target - count_q;
  assign lin_down = (cmd.cmd_target < count_q);
  assign mod_down = (up_dist > HALF);

  assign count_step = dir_q ? (count_q - 1'b1)
                            : (count_q + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      dwell_q  <= '0;
`ifdef UDC_STEP_LOG_EN
      step_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      dwell_q  <= dwell_d;
`ifdef UDC_STEP_LOG_EN
      step_q   <= step_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
`ifdef UDC_STEP_LOG_EN
    step_d   = step_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = cmd.cmd_target;
`ifdef UDC_STEP_LOG_EN
          step_d   = '0;
`endif
          if (cmd.cmd_target == count_q) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            dwell_d = DWELL_LAST;
            unique case (1'b1)
              cmd.cmd_wrap:  dir_d = mod_down;
              !cmd.cmd_wrap: dir_d = lin_down;
            endcase
          end
        end
      end
      RUN: begin
        if (step_en) begin
          count_d = count_step;
          dwell_d = DWELL_LAST;
`ifdef UDC_STEP_LOG_EN
          step_d  = step_q + 1'b1;
`endif
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
        // A coinciding step still lands; abort then wins over done.
        if (cmd.abort) begin
          state_d = IDLE;
        end else if (step_en && (count_step == target_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
